mfp_bot_upd_responder: RTL and testbench

//  CPU-side end of the Rojobot update handshake. Watches the latched IO_BotUpdt_Sync

---
 rtl/mfp_bot_upd_responder_pkg.sv | 37 +++
 rtl/mfp_bot_upd_responder_if.sv | 24 ++
 rtl/mfp_bot_upd_responder_sat_counter.sv | 36 +++
 rtl/mfp_bot_upd_responder.sv | 153 +++++++++++++++
 tb/tb_mfp_bot_upd_responder.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/mfp_bot_upd_responder_pkg.sv
// Shared definitions for the Rojobot update responder.
//  - FSM state encoding
//  - register map addresses
//  - CTRL / STATUS bit positions
//  - helper that packs the STATUS word
package mfp_bot_upd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_ACK     = 2'd2
  } state_e;

  localparam logic [1:0] ADDR_SNAP   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_RSVD   = 2'd3;

  localparam int CTRL_ACK_BIT     = 0;
  localparam int CTRL_IRQ_EN_BIT  = 1;
  localparam int CTRL_CLR_OVR_BIT = 2;
  localparam int CTRL_CLR_ERR_BIT = 3;

  localparam int STAT_PENDING_BIT = 0;
  localparam int STAT_BUSY_BIT    = 1;
  localparam int STAT_OVR_LSB     = 8;
  localparam int STAT_ERR_BIT     = 31;

  // STATUS = {err_to, ovr_cnt (zero-extended into [30:8]), 6'b0, busy, pending}
  function automatic logic [31:0] pack_status(input logic        err,
                                              input logic [22:0] ovr,
                                              input logic        busy,
                                              input logic        pending);
    pack_status = {err, ovr, 6'b000000, busy, pending};
  endfunction

endpackage

// File: rtl/mfp_bot_upd_responder_if.sv
// Bundle of the handshake and CPU register-bus signals of the responder.
//  slave  : the responder side (drives IO_INT_ACK, reg_rdata, irq_out)
//  master : the bot/handshake + CPU side (drives everything else)
interface mfp_bot_upd_responder_if;
  logic        IO_BotUpdt;
  logic        IO_BotUpdt_Sync;
  logic        IO_INT_ACK;
  logic [31:0] bot_regs_in;
  logic [1:0]  reg_addr;
  logic        reg_we;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;
  logic        irq_out;

  modport slave (
    input  IO_BotUpdt, IO_BotUpdt_Sync, bot_regs_in, reg_addr, reg_we, reg_wdata,
    output IO_INT_ACK, reg_rdata, irq_out
  );

  modport master (
    output IO_BotUpdt, IO_BotUpdt_Sync, bot_regs_in, reg_addr, reg_we, reg_wdata,
    input  IO_INT_ACK, reg_rdata, irq_out
  );
endinterface

// File: rtl/mfp_bot_upd_responder_sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats increment).
//  clk1_in : clock
//  resetn  : asynchronous active-low reset
//  inc     : count up by one unless already all-ones
//  clr     : zero the count
//  q       : current count
module mfp_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk1_in,
  input  logic         resetn,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

  logic [W-1:0] cnt_r;

  // Count register: clear has priority, increments stop at all-ones.
  always_ff @(posedge clk1_in or negedge resetn) begin
    if (!resetn) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (inc && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign q = cnt_r;

endmodule

// File: rtl/mfp_bot_upd_responder.sv
// CPU-side end of the Rojobot update handshake.
// On a latched update flag it snapshots the bot registers and raises an IRQ;
// after software (or AUTO_ACK) acknowledges, it holds IO_INT_ACK until the
// flag is seen low. A sticky timeout flags an ACK that is never answered.
//  clk1_in : system clock
//  resetn  : asynchronous active-low reset
//  bus     : handshake + register bus (slave side)
//    reg_addr 0=SNAP 1=STATUS 2=CTRL 3=reserved; CTRL b0 ACK b1 IRQ_EN b2 CLR_OVR b3 CLR_ERR
module mfp_bot_upd_responder
  import mfp_bot_upd_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16,
  parameter bit AUTO_ACK    = 1'b0,
  parameter int OVR_W       = 8
) (
  input logic                    clk1_in,
  input logic                    resetn,
  mfp_bot_upd_responder_if.slave bus
);

  localparam int              TO_W   = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LIM = TO_W'(ACK_TIMEOUT - 1);

  state_e           state_r, state_nxt_s;
  logic             int_ack_r, int_ack_nxt_s;
  logic             pending_r, pending_nxt_s;
  logic             irq_en_r, irq_en_nxt_s;
  logic             err_to_r, err_to_nxt_s;
  logic             irq_r;
  logic [31:0]      snap_r;
  logic [TO_W-1:0]  to_cnt_r, to_cnt_nxt_s;
  logic             capture_s, err_set_s;
  logic             ctrl_wr_s, ack_req_s, ovr_inc_s, ovr_clr_s, err_clr_s;
  logic [OVR_W-1:0] ovr_cnt_s;

  assign ctrl_wr_s = bus.reg_we && (bus.reg_addr == ADDR_CTRL);
  // With AUTO_ACK the very first PENDING cycle acknowledges.
  assign ack_req_s = AUTO_ACK || (ctrl_wr_s && bus.reg_wdata[CTRL_ACK_BIT]);
  assign ovr_inc_s = bus.IO_BotUpdt && ((state_r == ST_PENDING) || (state_r == ST_ACK));
  assign ovr_clr_s = ctrl_wr_s && bus.reg_wdata[CTRL_CLR_OVR_BIT];
  assign err_clr_s = ctrl_wr_s && bus.reg_wdata[CTRL_CLR_ERR_BIT];

  mfp_sat_counter #(.W(OVR_W)) u_ovr_cnt (
    .clk1_in (clk1_in),
    .resetn  (resetn),
    .inc     (ovr_inc_s),
    .clr     (ovr_clr_s),
    .q       (ovr_cnt_s)
  );

  // Next-state and next-value logic of the handshake FSM.
  always_comb begin
    state_nxt_s   = state_r;
    int_ack_nxt_s = int_ack_r;
    pending_nxt_s = pending_r;
    to_cnt_nxt_s  = to_cnt_r;
    capture_s     = 1'b0;
    err_set_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        int_ack_nxt_s = 1'b0;
        if (bus.IO_BotUpdt_Sync) begin
          capture_s     = 1'b1;
          pending_nxt_s = 1'b1;
          state_nxt_s   = ST_PENDING;
        end else begin
          pending_nxt_s = 1'b0;
        end
      end
      ST_PENDING: begin
        if (ack_req_s) begin
          int_ack_nxt_s = 1'b1;
          pending_nxt_s = 1'b0;
          to_cnt_nxt_s  = '0;
          state_nxt_s   = ST_ACK;
        end else begin
          int_ack_nxt_s = 1'b0;
        end
      end
      ST_ACK: begin
        if (!bus.IO_BotUpdt_Sync) begin
          int_ack_nxt_s = 1'b0;
          state_nxt_s   = ST_IDLE;
        end else begin
          int_ack_nxt_s = 1'b1;
          // Count up to the limit and flag the timeout on the cycle it is reached.
          if (to_cnt_r != TO_LIM) begin
            to_cnt_nxt_s = to_cnt_r + TO_W'(1);
            err_set_s    = ((to_cnt_r + TO_W'(1)) == TO_LIM);
          end else begin
            to_cnt_nxt_s = to_cnt_r;
          end
        end
      end
      default: begin
        int_ack_nxt_s = 1'b0;
        pending_nxt_s = 1'b0;
        state_nxt_s   = ST_IDLE;
      end
    endcase
  end

  // Control-register side effects; a timeout set beats a same-cycle clear.
  always_comb begin
    irq_en_nxt_s = ctrl_wr_s ? bus.reg_wdata[CTRL_IRQ_EN_BIT] : irq_en_r;
    if (err_set_s) begin
      err_to_nxt_s = 1'b1;
    end else if (err_clr_s) begin
      err_to_nxt_s = 1'b0;
    end else begin
      err_to_nxt_s = err_to_r;
    end
  end

  // State, snapshot and output registers.
  always_ff @(posedge clk1_in or negedge resetn) begin
    if (!resetn) begin
      state_r   <= ST_IDLE;
      int_ack_r <= 1'b0;
      pending_r <= 1'b0;
      irq_en_r  <= 1'b0;
      err_to_r  <= 1'b0;
      irq_r     <= 1'b0;
      snap_r    <= 32'h0000_0000;
      to_cnt_r  <= '0;
    end else begin
      state_r   <= state_nxt_s;
      int_ack_r <= int_ack_nxt_s;
      pending_r <= pending_nxt_s;
      irq_en_r  <= irq_en_nxt_s;
      err_to_r  <= err_to_nxt_s;
      irq_r     <= pending_nxt_s & irq_en_nxt_s;
      snap_r    <= capture_s ? bus.bot_regs_in : snap_r;
      to_cnt_r  <= to_cnt_nxt_s;
    end
  end

  // Zero-latency read mux over registered state.
  always_comb begin
    case (bus.reg_addr)
      ADDR_SNAP:   bus.reg_rdata = snap_r;
      ADDR_STATUS: bus.reg_rdata = pack_status(err_to_r, 23'(ovr_cnt_s),
                                               (state_r != ST_IDLE), pending_r);
      ADDR_CTRL:   bus.reg_rdata = {30'd0, irq_en_r, 1'b0};
      ADDR_RSVD:   bus.reg_rdata = 32'h0000_0000;
      default:     bus.reg_rdata = 32'h0000_0000;
    endcase
  end

  assign bus.IO_INT_ACK = int_ack_r;
  assign bus.irq_out    = irq_r;

endmodule

// File: tb/tb_mfp_bot_upd_responder.sv
module tb_mfp_bot_upd_responder;
  import mfp_bot_upd_pkg::*;

  logic clk1_in;
  logic resetn;
  int   checks;
  int   failures;

  mfp_bot_upd_responder_if b0 ();
  mfp_bot_upd_responder_if b1 ();

  mfp_bot_upd_responder #(.ACK_TIMEOUT(16), .AUTO_ACK(1'b0), .OVR_W(8)) dut (
    .clk1_in (clk1_in),
    .resetn  (resetn),
    .bus     (b0)
  );

  mfp_bot_upd_responder #(.ACK_TIMEOUT(16), .AUTO_ACK(1'b1), .OVR_W(8)) dut_auto (
    .clk1_in (clk1_in),
    .resetn  (resetn),
    .bus     (b1)
  );

  initial clk1_in = 1'b0;
  always #5 clk1_in = ~clk1_in;

  task automatic step();
    @(posedge clk1_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reg0(input string tag, input logic [1:0] a, input logic [31:0] exp);
    b0.reg_addr = a;
    #1;
    chk(tag, b0.reg_rdata, exp);
  endtask

  task automatic chk_reg1(input string tag, input logic [1:0] a, input logic [31:0] exp);
    b1.reg_addr = a;
    #1;
    chk(tag, b1.reg_rdata, exp);
  endtask

  task automatic ctrl_write0(input logic [31:0] d);
    b0.reg_addr  = ADDR_CTRL;
    b0.reg_wdata = d;
    b0.reg_we    = 1'b1;
    step();
    b0.reg_we    = 1'b0;
    b0.reg_wdata = 32'h0000_0000;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    resetn   = 1'b0;
    b0.IO_BotUpdt = 1'b0; b0.IO_BotUpdt_Sync = 1'b0; b0.bot_regs_in = 32'h0000_0000;
    b0.reg_addr = 2'd0; b0.reg_we = 1'b0; b0.reg_wdata = 32'h0000_0000;
    b1.IO_BotUpdt = 1'b0; b1.IO_BotUpdt_Sync = 1'b0; b1.bot_regs_in = 32'h0000_0000;
    b1.reg_addr = 2'd0; b1.reg_we = 1'b0; b1.reg_wdata = 32'h0000_0000;

    // Reset state
    step(); step();
    chk("rst_ack", {31'd0, b0.IO_INT_ACK}, 32'd0);
    chk("rst_irq", {31'd0, b0.irq_out}, 32'd0);
    chk_reg0("rst_status", ADDR_STATUS, 32'h0000_0000);
    chk_reg0("rst_snap", ADDR_SNAP, 32'h0000_0000);
    resetn = 1'b1;
    step();

    // ACK written in IDLE is ignored; irq_en becomes 1
    ctrl_write0(32'h0000_0003);
    chk("idle_ack_ignored", {31'd0, b0.IO_INT_ACK}, 32'd0);
    chk_reg0("idle_status", ADDR_STATUS, 32'h0000_0000);
    chk_reg0("reserved_reads0", ADDR_RSVD, 32'h0000_0000);

    // 1: capture
    b0.bot_regs_in     = 32'hA1B2_C3D4;
    b0.IO_BotUpdt_Sync = 1'b1;
    step();
    b0.bot_regs_in = 32'h1234_5678;
    chk_reg0("cap_snap", ADDR_SNAP, 32'hA1B2_C3D4);
    chk_reg0("cap_status", ADDR_STATUS, 32'h0000_0003);
    chk("cap_irq", {31'd0, b0.irq_out}, 32'd1);
    chk("cap_ack_low", {31'd0, b0.IO_INT_ACK}, 32'd0);
    step();
    chk_reg0("snap_hold", ADDR_SNAP, 32'hA1B2_C3D4);

    // 3: overrun counting while PENDING
    for (int i = 0; i < 3; i++) begin
      b0.IO_BotUpdt = 1'b1; step();
      b0.IO_BotUpdt = 1'b0; step();
    end
    chk_reg0("ovr_3", ADDR_STATUS, 32'h0000_0303);
    for (int i = 0; i < 300; i++) begin
      b0.IO_BotUpdt = 1'b1; step();
      b0.IO_BotUpdt = 1'b0; step();
    end
    chk_reg0("ovr_sat", ADDR_STATUS, 32'h0000_FF03);
    // clear together with an increment: clear wins
    b0.IO_BotUpdt = 1'b1;
    ctrl_write0(32'h0000_0006);
    b0.IO_BotUpdt = 1'b0;
    chk_reg0("ovr_clr", ADDR_STATUS, 32'h0000_0003);
    chk("ovr_clr_irq_en_kept", {31'd0, b0.irq_out}, 32'd1);

    // 2: ACK handshake, sync dropped one cycle after ACK
    ctrl_write0(32'h0000_0003);
    chk("ack_hi_1", {31'd0, b0.IO_INT_ACK}, 32'd1);
    chk("ack_irq_low", {31'd0, b0.irq_out}, 32'd0);
    chk_reg0("ack_status", ADDR_STATUS, 32'h0000_0002);
    step();
    chk("ack_hi_2", {31'd0, b0.IO_INT_ACK}, 32'd1);
    b0.IO_BotUpdt_Sync = 1'b0;
    step();
    chk("ack_low", {31'd0, b0.IO_INT_ACK}, 32'd0);
    chk_reg0("done_status", ADDR_STATUS, 32'h0000_0000);
    chk("done_irq", {31'd0, b0.irq_out}, 32'd0);

    // 4: ACK timeout
    b0.IO_BotUpdt_Sync = 1'b1;
    step();
    chk_reg0("to_cap_status", ADDR_STATUS, 32'h0000_0003);
    ctrl_write0(32'h0000_0003);
    for (int i = 0; i < 14; i++) step();
    chk_reg0("to_before", ADDR_STATUS, 32'h0000_0002);
    step();
    chk_reg0("to_set", ADDR_STATUS, 32'h8000_0002);
    chk("to_ack_held", {31'd0, b0.IO_INT_ACK}, 32'd1);
    for (int i = 0; i < 5; i++) step();
    chk("to_ack_held_20", {31'd0, b0.IO_INT_ACK}, 32'd1);
    b0.IO_BotUpdt_Sync = 1'b0;
    step();
    chk_reg0("to_idle", ADDR_STATUS, 32'h8000_0000);
    chk("to_ack_low", {31'd0, b0.IO_INT_ACK}, 32'd0);
    ctrl_write0(32'h0000_000A);
    chk_reg0("err_clr", ADDR_STATUS, 32'h0000_0000);

    // 5: AUTO_ACK instance
    b1.IO_BotUpdt_Sync = 1'b1;
    step();
    chk("auto_cap_ack", {31'd0, b1.IO_INT_ACK}, 32'd0);
    chk_reg1("auto_cap_status", ADDR_STATUS, 32'h0000_0003);
    step();
    chk("auto_ack_hi", {31'd0, b1.IO_INT_ACK}, 32'd1);
    chk_reg1("auto_ack_status", ADDR_STATUS, 32'h0000_0002);
    b1.IO_BotUpdt_Sync = 1'b0;
    step();
    chk("auto_ack_low", {31'd0, b1.IO_INT_ACK}, 32'd0);

    // 6: async reset while in ACK, then re-capture
    b0.IO_BotUpdt_Sync = 1'b1;
    step();
    ctrl_write0(32'h0000_0001);
    chk("pre_rst_ack", {31'd0, b0.IO_INT_ACK}, 32'd1);
    #1;
    resetn = 1'b0;
    #1;
    chk("async_rst_ack", {31'd0, b0.IO_INT_ACK}, 32'd0);
    chk_reg0("async_rst_status", ADDR_STATUS, 32'h0000_0000);
    step();
    resetn = 1'b1;
    step();
    chk_reg0("recap_status", ADDR_STATUS, 32'h0000_0003);
    chk_reg0("recap_snap", ADDR_SNAP, 32'h1234_5678);
    chk("recap_irq_off", {31'd0, b0.irq_out}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
